// File: rtl/fpu_fp80_to_int_seq_pkg.sv
// Shared definitions for the FP80 -> integer conversion path: field layout,
// exponent constants, rounding-mode encodings and the converter FSM encoding.
package fpu_fp80_pkg;

  localparam int FP_SIGN_BIT = 79;
  localparam int FP_EXP_HI   = 78;
  localparam int FP_EXP_LO   = 64;
  localparam int FP_MANT_HI  = 63;
  localparam int FP_MANT_LO  = 0;

  localparam int          EXP_BIAS = 16383;
  localparam logic [14:0] EXP_MAX  = 15'h7FFF;

  localparam logic [1:0] RM_NEAREST = 2'b00;
  localparam logic [1:0] RM_DOWN    = 2'b01;
  localparam logic [1:0] RM_UP      = 2'b10;
  localparam logic [1:0] RM_TRUNC   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLASSIFY = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_ROUND    = 3'd3,
    ST_DONE     = 3'd4
  } fsm_state_e;

endpackage

// File: rtl/fpu_fp80_to_int_seq_if.sv
// Operand/result bundle between the microsequencer, the converter and the
// store-data path, plus a debug view of the converter FSM.
interface fpu_fp80_to_int_seq_if #(
  parameter int INT_WIDTH = 16
);
  import fpu_fp80_pkg::*;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The producer holds its payload stable while valid && !ready. abort
  // cancels any in-flight operand and takes precedence over out_ready.
  logic                 in_valid;
  logic                 in_ready;
  logic [79:0]          fp_in;
  logic [1:0]           rounding_mode;
  logic                 abort;
  logic                 out_valid;
  logic                 out_ready;
  logic [INT_WIDTH-1:0] int_out;
  logic                 flag_invalid;
  logic                 flag_precision;
  logic                 flag_denormal;
  fsm_state_e           dbg_state;

  modport slave (
    input  in_valid, fp_in, rounding_mode, abort, out_ready,
    output in_ready, out_valid, int_out,
    output flag_invalid, flag_precision, flag_denormal, dbg_state
  );

  modport master (
    output in_valid, fp_in, rounding_mode, abort, out_ready,
    input  in_ready, out_valid, int_out,
    input  flag_invalid, flag_precision, flag_denormal, dbg_state
  );

endinterface

// File: rtl/fpu_fp80_to_int_seq_round_unit.sv
// Combinational integer rounding: applies the rounding mode to a magnitude
// with guard/sticky bits, then signs the result and range-checks it.
module fpu_int_round_unit
  import fpu_fp80_pkg::*;
#(
  parameter int INT_WIDTH = 16
) (
  input  logic                 sign_i,
  input  logic [64:0]          mag_i,
  input  logic                 guard_i,
  input  logic                 sticky_i,
  input  logic [1:0]           mode_i,
  output logic [INT_WIDTH-1:0] value_o,
  output logic                 inexact_o,
  output logic                 range_ok_o
);

  localparam logic [64:0] NEG_LIMIT = 65'd1 << (INT_WIDTH - 1);
  localparam logic [64:0] POS_LIMIT = NEG_LIMIT - 65'd1;

  logic        inc;
  logic [64:0] rmag;

  always_comb begin
    inexact_o = guard_i | sticky_i;
    inc       = 1'b0;
    case (mode_i)
      RM_NEAREST: inc = guard_i & (sticky_i | mag_i[0]);
      RM_DOWN:    inc = sign_i & inexact_o;
      RM_UP:      inc = ~sign_i & inexact_o;
      default:    inc = 1'b0;
    endcase
    // 65-bit magnitude so that rounding 2^64-1 up cannot wrap
    rmag       = mag_i + {64'd0, inc};
    range_ok_o = sign_i ? (rmag <= NEG_LIMIT) : (rmag <= POS_LIMIT);
    value_o    = sign_i ? (~rmag[INT_WIDTH-1:0] + INT_WIDTH'(1))
                        : rmag[INT_WIDTH-1:0];
  end

endmodule

// File: rtl/fpu_fp80_to_int_seq.sv
// Sequential FP80 -> signed INT_WIDTH converter (FIST/FISTP): classify, then an
// iterative right shifter, then rounding and a held result.
module fpu_fp80_to_int_seq
  import fpu_fp80_pkg::*;
#(
  parameter int INT_WIDTH  = 16,
  parameter int SHIFT_STEP = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  fpu_fp80_to_int_seq_if.slave io
);

  localparam logic [INT_WIDTH-1:0] INDEF    = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam logic [14:0]          EXP_OVF  = 15'(EXP_BIAS + INT_WIDTH - 1);
  localparam logic [14:0]          EXP_TINY = 15'(EXP_BIAS - 1);
  localparam logic [14:0]          SH_BASE  = 15'(EXP_BIAS + 63);
  localparam logic [6:0]           STEP     = 7'(SHIFT_STEP);

  fsm_state_e           state_q, state_d;
  logic                 sign_q, sign_d;
  logic [14:0]          exp_q, exp_d;
  logic [64:0]          wk_q, wk_d;        // {mantissa/magnitude, guard}
  logic                 sticky_q, sticky_d;
  logic [6:0]           rem_q, rem_d;
  logic [1:0]           mode_q, mode_d;
  logic [INT_WIDTH-1:0] int_q, int_d;
  logic                 inv_q, inv_d;
  logic                 prec_q, prec_d;
  logic                 den_q, den_d;

  logic [63:0]          mant;
  logic                 special, is_zero, denorm;
  logic [6:0]           sh_amt, amt;
  logic [64:0]          lost_mask;
  logic [INT_WIDTH-1:0] rnd_value;
  logic                 rnd_inexact, rnd_range_ok;

  assign mant      = wk_q[64:1];
  assign special   = (exp_q == EXP_MAX) || ((exp_q != 15'd0) && !mant[63]);
  assign is_zero   = (exp_q == 15'd0) && (mant == 64'd0);
  assign denorm    = (exp_q == 15'd0) && (mant != 64'd0);
  assign sh_amt    = 7'(SH_BASE - exp_q);
  assign amt       = (rem_q < STEP) ? rem_q : STEP;
  assign lost_mask = (65'd1 << amt) - 65'd1;

  fpu_int_round_unit #(.INT_WIDTH(INT_WIDTH)) u_round (
    .sign_i     (sign_q),
    .mag_i      ({1'b0, mant}),
    .guard_i    (wk_q[0]),
    .sticky_i   (sticky_q),
    .mode_i     (mode_q),
    .value_o    (rnd_value),
    .inexact_o  (rnd_inexact),
    .range_ok_o (rnd_range_ok)
  );

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    wk_d     = wk_q;
    sticky_d = sticky_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    int_d    = int_q;
    inv_d    = inv_q;
    prec_d   = prec_q;
    den_d    = den_q;
    if (io.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (io.in_valid) begin
          sign_d   = io.fp_in[FP_SIGN_BIT];
          exp_d    = io.fp_in[FP_EXP_HI:FP_EXP_LO];
          wk_d     = {io.fp_in[FP_MANT_HI:FP_MANT_LO], 1'b0};
          sticky_d = 1'b0;
          mode_d   = io.rounding_mode;
          inv_d    = 1'b0;
          prec_d   = 1'b0;
          den_d    = 1'b0;
          state_d  = ST_CLASSIFY;
        end
        ST_CLASSIFY: begin
          state_d = ST_DONE;
          if (special) begin
            int_d = INDEF;
            inv_d = 1'b1;
          end else if (is_zero) begin
            int_d = '0;
          end else if (denorm || (exp_q < EXP_TINY)) begin
            // |x| < 0.5: only the directed modes can move away from zero
            if ((mode_q == RM_DOWN) && sign_q)     int_d = '1;
            else if ((mode_q == RM_UP) && !sign_q) int_d = INT_WIDTH'(1);
            else                                   int_d = '0;
            prec_d = 1'b1;
            den_d  = denorm;
          end else if (exp_q > EXP_OVF) begin
            int_d = INDEF;
            inv_d = 1'b1;
          end else begin
            rem_d   = sh_amt;
            state_d = (sh_amt == 7'd0) ? ST_ROUND : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          wk_d     = wk_q >> amt;
          sticky_d = sticky_q | (|(wk_q & lost_mask));
          rem_d    = rem_q - amt;
          if (rem_q == amt) state_d = ST_ROUND;
        end
        ST_ROUND: begin
          state_d = ST_DONE;
          if (rnd_range_ok) begin
            int_d  = rnd_value;
            prec_d = rnd_inexact;
          end else begin
            int_d  = INDEF;
            inv_d  = 1'b1;
            prec_d = 1'b0;
          end
        end
        ST_DONE: if (io.out_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      wk_q     <= '0;
      sticky_q <= 1'b0;
      rem_q    <= '0;
      mode_q   <= RM_NEAREST;
      int_q    <= '0;
      inv_q    <= 1'b0;
      prec_q   <= 1'b0;
      den_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      wk_q     <= wk_d;
      sticky_q <= sticky_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      int_q    <= int_d;
      inv_q    <= inv_d;
      prec_q   <= prec_d;
      den_q    <= den_d;
    end
  end

  assign io.in_ready       = (state_q == ST_IDLE);
  assign io.out_valid      = (state_q == ST_DONE);
  assign io.int_out        = int_q;
  assign io.flag_invalid   = inv_q;
  assign io.flag_precision = prec_q;
  assign io.flag_denormal  = den_q;
  assign io.dbg_state      = state_q;

endmodule
